// File: rtl/clkdiv_scale_arbiter_pkg.sv
// Shared definitions for the divider-scale arbiter.
// Holds the FSM state encoding and the default parameter values used by
// the arbiter top level, its round-robin selector and the requester interface.
package clkdiv_pkg;

    // Default parameter values
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_NREQ        = 4;
    localparam int DEF_RESET_SCALE = 1;
    localparam int DEF_TIMEOUT     = 1024;

    // FSM state encoding (plain constants so legacy code can share them)
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARB       = 3'd1;
    localparam logic [2:0] ST_WAIT_EDGE = 3'd2;
    localparam logic [2:0] ST_LOAD      = 3'd3;
    localparam logic [2:0] ST_SETTLE    = 3'd4;

endpackage

// File: rtl/clkdiv_scale_arbiter_if.sv
// Requester-side bus of the divider-scale arbiter.
//   req       : per-requester level request, held until grant
//   req_scale : requester i's scale in bits [i*WIDTH +: WIDTH]
//   grant     : one-hot, one-cycle acknowledge of a completed change
//   busy      : arbiter is not idle
// Modport slave is the arbiter's view; master is the requesters' view.
interface clkdiv_scale_arbiter_if
    import clkdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_scale;
    logic [NREQ-1:0]       grant;
    logic                  busy;

    modport slave (
        input  req,
        input  req_scale,
        output grant,
        output busy
    );

    modport master (
        output req,
        output req_scale,
        input  grant,
        input  busy
    );
endinterface

// File: rtl/clkdiv_scale_arbiter_rr_arbiter.sv
// Combinational round-robin selector.
//   req      : request vector
//   rr_ptr   : index with highest priority this round
//   win      : one-hot winner (all zero when no request)
//   win_idx  : binary index of the winner
//   win_vld  : at least one request is pending
// The winner is the first set request at or after rr_ptr, wrapping around.
module rr_arbiter
    import clkdiv_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    // NOTE: every output gets a default before the search loop, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        win     = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!win_vld && req[j]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(j);
                win[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkdiv_scale_arbiter.sv
// Arbitrates scale-change requests for a clock divider.
// Requesters raise req with a scale; the winner's scale is loaded into the
// divider on a falling edge of the divider output (or after a timeout, or at
// once when the divider is in bypass), with div_nrst pulsed low for one cycle
// while the new scale is presented. A one-cycle grant then acknowledges it.
// Ports:
//   clk_in      : clock, all logic on the rising edge
//   rst         : synchronous active-high reset
//   bus         : requester bus (req, req_scale, grant, busy)
//   div_clk_out : divider output, generated from clk_in
//   div_scale   : scale applied to the divider
//   div_nrst    : active-low divider reset, divider samples div_scale while low
module clkdiv_scale_arbiter
    import clkdiv_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NREQ        = DEF_NREQ,
    parameter int RESET_SCALE = DEF_RESET_SCALE,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                   clk_in,
    input  logic                   rst,
    clkdiv_scale_arbiter_if.slave  bus,
    input  logic                   div_clk_out,
    output logic [WIDTH-1:0]       div_scale,
    output logic                   div_nrst
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    logic [2:0]       state, state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [WIDTH-1:0] win_scale;
    logic [CNT_W-1:0] cnt;
    logic             div_q;
    logic             div_fall;

    logic [NREQ-1:0]  arb_win;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_vld;
    logic [WIDTH-1:0] arb_scale;
    logic [NREQ-1:0]  grant_nxt;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .win     (arb_win),
        .win_idx (arb_idx),
        .win_vld (arb_vld)
    );

    assign arb_scale = bus.req_scale[arb_idx*WIDTH +: WIDTH];

    // Previous divider level is the registered copy; current is the live pin.
    assign div_fall = div_q && !div_clk_out;

    // The unchanged-scale path goes ARB -> SETTLE in one step, before win_idx
    // is latched, so the grant then comes straight from the selector.
    assign grant_nxt = (state == ST_ARB) ? arb_win : (NREQ'(1) << win_idx);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                if (!arb_vld) begin
                    state_nxt = ST_IDLE;
                end else if (arb_scale == div_scale) begin
                    state_nxt = ST_SETTLE;
                end else begin
                    state_nxt = ST_WAIT_EDGE;
                end
            end
            ST_WAIT_EDGE: begin
                // A withdrawn request abandons the change before any reload.
                if (!bus.req[win_idx]) begin
                    state_nxt = ST_IDLE;
                end else if (div_fall || (div_scale == '0) || (cnt == CNT_LAST)) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD:   state_nxt = ST_SETTLE;
            ST_SETTLE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            win_idx   <= '0;
            win_scale <= '0;
            cnt       <= '0;
            div_q     <= 1'b0;
            div_scale <= WIDTH'(RESET_SCALE);
            div_nrst  <= 1'b0;
            bus.grant <= '0;
            bus.busy  <= 1'b0;
        end else begin
            state     <= state_nxt;
            div_q     <= div_clk_out;
            bus.busy  <= (state_nxt != ST_IDLE);
            bus.grant <= '0;
            div_nrst  <= 1'b1;

            if (state == ST_ARB) begin
                win_idx   <= arb_idx;
                win_scale <= arb_scale;
                cnt       <= '0;
            end

            // Saturating wait counter.
            if (state == ST_WAIT_EDGE && cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end

            if (state_nxt == ST_LOAD) begin
                div_scale <= win_scale;
                div_nrst  <= 1'b0;
            end

            if (state_nxt == ST_SETTLE) begin
                bus.grant <= grant_nxt;
            end

            if (state == ST_SETTLE) begin
                rr_ptr <= (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_scale_arbiter.sv
// Directed self-checking bench for clkdiv_scale_arbiter (WIDTH=8, NREQ=4,
// RESET_SCALE=1, TIMEOUT=16). div_clk_out is driven directly so falling edges
// land exactly where each step needs them.
module tb_clkdiv_scale_arbiter;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       div_clk_out;
    logic [7:0] div_scale;
    logic       div_nrst;

    int n_assert = 0;
    int n_fail   = 0;

    clkdiv_scale_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

    clkdiv_scale_arbiter #(
        .WIDTH       (8),
        .NREQ        (4),
        .RESET_SCALE (1),
        .TIMEOUT     (16)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .bus         (bus),
        .div_clk_out (div_clk_out),
        .div_scale   (div_scale),
        .div_nrst    (div_nrst)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic set_req(input int idx, input logic [7:0] scale);
        bus.req_scale[idx*8 +: 8] = scale;
        bus.req[idx] = 1'b1;
    endtask

    // DUT is idle with req already set. Runs one transaction, supplying a
    // falling edge in the first WAIT_EDGE cycle when a reload is expected,
    // and drops req[idx] on its grant.
    task automatic run_txn(input string tag, input int idx, input logic [7:0] scale,
                           input logic [7:0] prev_scale, input logic reload);
        logic [3:0] exp_gnt;
        exp_gnt = 4'b0001 << idx;
        div_clk_out = 1'b1;
        step();
        chk({tag, "_arb_busy"},  32'(bus.busy),  32'd1);
        chk({tag, "_arb_grant"}, 32'(bus.grant), 32'd0);
        chk({tag, "_arb_scale"}, 32'(div_scale), 32'(prev_scale));
        step();
        if (reload) begin
            chk({tag, "_wait_nrst"},  32'(div_nrst),  32'd1);
            chk({tag, "_wait_scale"}, 32'(div_scale), 32'(prev_scale));
            div_clk_out = 1'b0;
            step();
            chk({tag, "_load_scale"}, 32'(div_scale), 32'(scale));
            chk({tag, "_load_nrst"},  32'(div_nrst),  32'd0);
            chk({tag, "_load_grant"}, 32'(bus.grant), 32'd0);
            div_clk_out = 1'b1;
            step();
        end
        chk({tag, "_settle_grant"}, 32'(bus.grant), 32'(exp_gnt));
        chk({tag, "_settle_nrst"},  32'(div_nrst),  32'd1);
        chk({tag, "_settle_scale"}, 32'(div_scale), 32'(scale));
        chk({tag, "_settle_busy"},  32'(bus.busy),  32'd1);
        bus.req[idx] = 1'b0;
        step();
        chk({tag, "_idle_grant"}, 32'(bus.grant), 32'd0);
        chk({tag, "_idle_busy"},  32'(bus.busy),  32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        div_clk_out   = 1'b0;
        bus.req       = '0;
        bus.req_scale = '0;

        // Reset state
        step();
        step();
        chk("rst_scale", 32'(div_scale), 32'd1);
        chk("rst_nrst",  32'(div_nrst),  32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_nrst",  32'(div_nrst),  32'd1);
        chk("post_rst_busy",  32'(bus.busy),  32'd0);
        chk("post_rst_scale", 32'(div_scale), 32'd1);

        // Unchanged scale: grant two cycles after request, no reload
        set_req(0, 8'd1);
        run_txn("same0", 0, 8'd1, 8'd1, 1'b0);

        // All four requesting, rr_ptr=1: order 1,2,3,0, back to back
        set_req(0, 8'd2);
        set_req(1, 8'd3);
        set_req(2, 8'd3);
        set_req(3, 8'd7);
        run_txn("rr1", 1, 8'd3, 8'd1, 1'b1);
        run_txn("rr2", 2, 8'd3, 8'd3, 1'b0);
        run_txn("rr3", 3, 8'd7, 8'd3, 1'b1);
        run_txn("rr0", 0, 8'd2, 8'd7, 1'b1);

        // Single reload: req[2] scale 5
        set_req(2, 8'd5);
        run_txn("req2", 2, 8'd5, 8'd2, 1'b1);

        // Timeout: divider output held high, LOAD 16 cycles after WAIT_EDGE entry
        div_clk_out = 1'b1;
        set_req(1, 8'd9);
        step();
        step();
        for (int i = 0; i < 15; i++) begin
            chk("to_wait_nrst", 32'(div_nrst), 32'd1);
            chk("to_wait_busy", 32'(bus.busy), 32'd1);
            step();
        end
        chk("to_wait_last_nrst", 32'(div_nrst), 32'd1);
        step();
        chk("to_load_nrst",  32'(div_nrst),  32'd0);
        chk("to_load_scale", 32'(div_scale), 32'd9);
        step();
        chk("to_grant", 32'(bus.grant), 32'h2);
        bus.req[1] = 1'b0;
        step();
        chk("to_idle_busy", 32'(bus.busy), 32'd0);

        // Request withdrawn during WAIT_EDGE: no grant, no reload
        set_req(3, 8'd4);
        step();
        step();
        chk("drop_wait_busy", 32'(bus.busy), 32'd1);
        bus.req[3] = 1'b0;
        step();
        chk("drop_idle_busy",  32'(bus.busy),  32'd0);
        chk("drop_idle_grant", 32'(bus.grant), 32'd0);
        chk("drop_idle_scale", 32'(div_scale), 32'd9);
        chk("drop_idle_nrst",  32'(div_nrst),  32'd1);
        step();
        chk("drop_later_grant", 32'(bus.grant), 32'd0);

        // rr_ptr stayed at 2, so req[3] beats req[1]; reset during the reload
        set_req(1, 8'd8);
        set_req(3, 8'd6);
        step();
        step();
        div_clk_out = 1'b0;
        step();
        chk("ptr_load_scale", 32'(div_scale), 32'd6);
        chk("ptr_load_nrst",  32'(div_nrst),  32'd0);
        rst = 1'b1;
        step();
        chk("abort_scale", 32'(div_scale), 32'd1);
        chk("abort_nrst",  32'(div_nrst),  32'd0);
        chk("abort_grant", 32'(bus.grant), 32'd0);
        chk("abort_busy",  32'(bus.busy),  32'd0);
        bus.req = '0;
        rst = 1'b0;
        step();
        chk("abort_post_nrst",  32'(div_nrst),  32'd1);
        chk("abort_post_grant", 32'(bus.grant), 32'd0);
        chk("abort_post_busy",  32'(bus.busy),  32'd0);
        chk("abort_post_scale", 32'(div_scale), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/clkdiv_scale_arbiter.md
CLKDIV_SCALE_ARBITER -- requirements
Module: clkdiv_scale_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: width of each scale value and of div_scale.
REQ-002 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-003 Parameter RESET_SCALE, default 1: scale driven to the divider after reset.
REQ-004 Parameter TIMEOUT, default 1024: maximum cycles spent waiting for a divider falling edge.
REQ-005 clk_in  input  1: single clock; all logic on its rising edge.
REQ-006 rst  input  1: reset, synchronous, active-high.
REQ-007 req  input  NREQ: per-requester scale-change request, level, held until grant.
REQ-008 req_scale  input  NREQ*WIDTH: requester i's scale in bits [i*WIDTH +: WIDTH]; stable while req[i] is high.
REQ-009 div_clk_out  input  1: divider output, generated from clk_in.
REQ-010 div_scale  output  WIDTH: scale applied to the divider.
REQ-011 div_nrst  output  1: active-low divider reset; divider samples div_scale while low.
REQ-012 grant  output  NREQ: one-hot, one-cycle acknowledge of a completed change.
REQ-013 busy  output  1: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ARB, WAIT_EDGE, LOAD, SETTLE.
REQ-015 IDLE: any req bit high -> ARB next cycle.
REQ-016 ARB: the winner SHALL be the first high req at or after rr_ptr, cyclically; its index and scale are latched.
- Latched scale equals div_scale: skip reload, go to SETTLE.
- Otherwise -> WAIT_EDGE.
REQ-017 WAIT_EDGE:
- div_clk_out is registered once; a falling edge is prev=1 and cur=0.
- On falling edge -> LOAD.
- If current div_scale==0 (divider in bypass), or the timeout counter reaches TIMEOUT-1 -> LOAD.
REQ-018 WAIT_EDGE: if the latched winner's req drops, the FSM SHALL return to IDLE with no grant, no reload and rr_ptr unchanged.
REQ-019 LOAD (exactly 1 cycle): div_scale = latched scale, div_nrst = 0 -> SETTLE.
REQ-020 SETTLE (exactly 1 cycle): div_nrst = 1; grant[winner] = 1; rr_ptr = (winner+1) mod NREQ -> IDLE.
REQ-021 Latency, from req sampled high in IDLE to grant, assuming a falling edge at the first WAIT_EDGE cycle:
- 4 cycles with a reload.
- 2 cycles when the scale is unchanged.
REQ-022 Requests arriving while busy are not lost.
- They are only arbitrated in the next ARB.
- A requester holding req after its grant is re-arbitrated as a fresh request.
REQ-023 The timeout counter SHALL be ceil(log2(TIMEOUT)) bits wide and cleared on entry to WAIT_EDGE.
- It saturates; it does not wrap.
REQ-024 div_scale SHALL change only in LOAD; div_nrst SHALL be low only in LOAD and during reset.
REQ-025 grant SHALL never have more than one bit set.
REQ-026 busy and grant SHALL be registered outputs.

Reset
REQ-027 When rst=1 at a clock edge:
- state = IDLE, rr_ptr = 0, counter = 0.
- div_scale = RESET_SCALE, div_nrst = 0, grant = 0, busy = 0.
REQ-028 First cycle after rst deasserts: div_nrst = 1.
REQ-029 rst asserted mid-transaction SHALL abort it with no grant issued.

Structure
REQ-030 A shared package (clkdiv_pkg) SHALL hold:
- the FSM state encoding;
- the default WIDTH, NREQ, RESET_SCALE and TIMEOUT constants.
REQ-031 The round-robin winner selection SHALL be a sub-module rr_arbiter:
- inputs: req, rr_ptr;
- outputs: one-hot winner and its index;
- combinational.
REQ-032 RTL size target: 120-400 lines including rr_arbiter.

Verification
REQ-033 After reset: div_scale=1, div_nrst low 1 cycle then high, grant=0, busy=0.
REQ-034 req[2] with scale 5, div_clk_out falling at the first WAIT_EDGE cycle:
- LOAD drives div_scale=5 with div_nrst=0;
- grant=4'b0100 two cycles later.
REQ-035 req=4'b1111, each requester holding req until its own grant, rr_ptr=1: grants in order 1,2,3,0 with no gap between transactions beyond REQ-021 latency.
REQ-036 req[0] with scale equal to current div_scale=1: grant[0] 2 cycles after the request; div_nrst never low.
REQ-037 div_clk_out held at 1, TIMEOUT=16: LOAD entered exactly 16 cycles after WAIT_EDGE entry.
REQ-038 req[3] dropped during WAIT_EDGE: FSM returns to IDLE, no grant, div_scale unchanged.
- A following rst during a reload returns div_scale to 1.
